// File: rtl/noc_local_ni.sv
// Local-port network interface: frames host commands into address/size/payload packets
// and deframes packets arriving from the router into a payload stream with a last marker.
module noc_local_ni #(
   parameter int unsigned TAM_FLIT = 16,
   parameter int unsigned NUM_X    = 4,
   parameter int unsigned NUM_Y    = 4,
   parameter int unsigned RX_DEPTH = 8,
   parameter int unsigned LEN_W    = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [TAM_FLIT-1:0] cmd_dest,
   input  logic [LEN_W-1:0]    cmd_len,
   input  logic                pl_valid,
   output logic                pl_ready,
   input  logic [TAM_FLIT-1:0] pl_data,
   output logic                tx,
   output logic [TAM_FLIT-1:0] data_out,
   input  logic                credit_i,
   input  logic                rx,
   input  logic [TAM_FLIT-1:0] data_in,
   output logic                credit_o,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic [TAM_FLIT-1:0] rx_data,
   output logic                rx_last,
   output logic                err_dest,
   output logic [15:0]         sent_pkts,
   output logic [15:0]         recv_pkts
);

   localparam int unsigned META  = TAM_FLIT / 2;
   localparam int unsigned PTR_W = $clog2(RX_DEPTH);

   typedef enum logic [2:0] {StIdle, StHdr, StSize, StPay, StDrop} inj_state_e;
   typedef enum logic [1:0] {StRHdr, StRSize, StRPay} rx_state_e;

   // ---------------- injection ----------------
   inj_state_e          inj_q, inj_d;
   logic [TAM_FLIT-1:0] dest_q, dest_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                err_q, err_d;
   logic [15:0]         sent_q, sent_d;
   logic                dest_ok;

   assign dest_ok = (32'(cmd_dest[TAM_FLIT-1:META]) < NUM_X) &&
                    (32'(cmd_dest[META-1:0]) < NUM_Y);

   always_comb begin
      inj_d     = inj_q;
      dest_d    = dest_q;
      len_d     = len_q;
      err_d     = 1'b0;
      sent_d    = sent_q;
      cmd_ready = 1'b0;
      tx        = 1'b0;
      data_out  = '0;
      pl_ready  = 1'b0;
      unique case (inj_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               dest_d = cmd_dest;
               len_d  = cmd_len;
               if (!dest_ok) begin
                  err_d = 1'b1;
                  if (cmd_len != '0) inj_d = StDrop;
               end else begin
                  inj_d = StHdr;
               end
            end
         end
         StHdr: begin
            tx       = 1'b1;
            data_out = dest_q;
            if (credit_i) inj_d = StSize;
         end
         StSize: begin
            tx       = 1'b1;
            data_out = TAM_FLIT'(len_q);
            if (credit_i) begin
               if (len_q == '0) begin
                  inj_d  = StIdle;
                  sent_d = sent_q + 16'd1;
               end else begin
                  inj_d = StPay;
               end
            end
         end
         StPay: begin
            // len_q counts remaining payload flits from here on
            tx       = pl_valid;
            data_out = pl_data;
            pl_ready = credit_i;
            if (pl_valid && credit_i) begin
               len_d = len_q - LEN_W'(1);
               if (len_q == LEN_W'(1)) begin
                  inj_d  = StIdle;
                  sent_d = sent_q + 16'd1;
               end
            end
         end
         StDrop: begin
            pl_ready = 1'b1;
            if (pl_valid) begin
               len_d = len_q - LEN_W'(1);
               if (len_q == LEN_W'(1)) inj_d = StIdle;
            end
         end
         default: inj_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         inj_q  <= StIdle;
         dest_q <= '0;
         len_q  <= '0;
         err_q  <= 1'b0;
         sent_q <= '0;
      end else begin
         inj_q  <= inj_d;
         dest_q <= dest_d;
         len_q  <= len_d;
         err_q  <= err_d;
         sent_q <= sent_d;
      end
   end

   assign err_dest  = err_q;
   assign sent_pkts = sent_q;

   // ---------------- ejection ----------------
   logic [TAM_FLIT-1:0] mem [RX_DEPTH];
   logic [PTR_W:0]      wr_q, rd_q;
   logic                empty, full, push, pop;
   logic [TAM_FLIT-1:0] head;
   rx_state_e           rx_q, rx_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [15:0]         recv_q, recv_d;

   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
   assign credit_o = !full;
   assign push     = rx && credit_o;
   assign head     = mem[rd_q[PTR_W-1:0]];

   always_comb begin
      rx_d     = rx_q;
      cnt_d    = cnt_q;
      recv_d   = recv_q;
      pop      = 1'b0;
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      rx_data  = '0;
      unique case (rx_q)
         StRHdr: begin
            if (!empty) begin
               pop  = 1'b1;
               rx_d = StRSize;
            end
         end
         StRSize: begin
            if (!empty) begin
               pop   = 1'b1;
               cnt_d = head[LEN_W-1:0];
               if (head[LEN_W-1:0] == '0) begin
                  rx_d   = StRHdr;
                  recv_d = recv_q + 16'd1;
               end else begin
                  rx_d = StRPay;
               end
            end
         end
         StRPay: begin
            if (!empty) begin
               rx_valid = 1'b1;
               rx_data  = head;
               rx_last  = (cnt_q == LEN_W'(1));
               if (rx_ready) begin
                  pop   = 1'b1;
                  cnt_d = cnt_q - LEN_W'(1);
                  if (cnt_q == LEN_W'(1)) begin
                     rx_d   = StRHdr;
                     recv_d = recv_q + 16'd1;
                  end
               end
            end
         end
         default: rx_d = StRHdr;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         rx_q   <= StRHdr;
         cnt_q  <= '0;
         recv_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + (PTR_W + 1)'(1);
         if (pop)  rd_q <= rd_q + (PTR_W + 1)'(1);
         rx_q   <= rx_d;
         cnt_q  <= cnt_d;
         recv_q <= recv_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_q[PTR_W-1:0]] <= data_in;
   end

   assign recv_pkts = recv_q;

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni: per-cycle vector table for inject/eject framing,
// plus hand-written sequences for FIFO back-pressure and mid-packet reset.
module tb_noc_local_ni;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready;
   logic [15:0] cmd_dest;
   logic [7:0]  cmd_len;
   logic        pl_valid, pl_ready;
   logic [15:0] pl_data;
   logic        tx;
   logic [15:0] data_out;
   logic        credit_i, rx, credit_o;
   logic [15:0] data_in;
   logic        rx_valid, rx_ready, rx_last, err_dest;
   logic [15:0] rx_data, sent_pkts, recv_pkts;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   noc_local_ni #(
      .TAM_FLIT(16), .NUM_X(4), .NUM_Y(4), .RX_DEPTH(8), .LEN_W(8)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
      .tx(tx), .data_out(data_out), .credit_i(credit_i),
      .rx(rx), .data_in(data_in), .credit_o(credit_o),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
      .err_dest(err_dest), .sent_pkts(sent_pkts), .recv_pkts(recv_pkts)
   );

   typedef struct {
      logic        cv;
      logic [15:0] dest;
      logic [7:0]  len;
      logic        pv;
      logic [15:0] pd;
      logic        cr;
      logic        rxv;
      logic [15:0] din;
      logic        rr;
      logic        e_cmd_ready;
      logic        e_tx;
      logic [15:0] e_dout;
      logic        e_pl_ready;
      logic        e_err;
      logic        e_rx_valid;
      logic [15:0] e_rx_data;
      logic        e_rx_last;
      logic [15:0] e_sent;
      logic [15:0] e_recv;
   } vec_t;

   localparam logic [15:0] PA = 16'hA001, PB = 16'hB002, PC = 16'hC003;
   vec_t vecs[37];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid = 0; cmd_dest = '0; cmd_len = '0; pl_valid = 0; pl_data = '0;
      credit_i = 0; rx = 0; data_in = '0; rx_ready = 0;
   endtask

   initial begin
      // inputs: cv dest len pv pd cr rxv din rr | expected: crdy tx dout plr err rxv rxd last sent recv
      // T1: clean injection, len=3
      vecs[0]  = '{1, 16'h0102, 3, 0, 0,  1, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{0, 0, 0, 1, PA, 1, 0, 0, 0,         0, 1, 16'h0102, 0, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{0, 0, 0, 1, PA, 1, 0, 0, 0,         0, 1, 16'h0003, 0, 0, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 0, 0, 1, PA, 1, 0, 0, 0,         0, 1, PA,       1, 0, 0, 0, 0, 0, 0};
      vecs[4]  = '{0, 0, 0, 1, PB, 1, 0, 0, 0,         0, 1, PB,       1, 0, 0, 0, 0, 0, 0};
      vecs[5]  = '{0, 0, 0, 1, PC, 1, 0, 0, 0,         0, 1, PC,       1, 0, 0, 0, 0, 0, 0};
      vecs[6]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,         1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0};
      // T2: credit low on 2nd and 4th tx cycles
      vecs[7]  = '{1, 16'h0102, 3, 0, 0,  1, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0};
      vecs[8]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0,         0, 1, 16'h0102, 0, 0, 0, 0, 0, 1, 0};
      vecs[9]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,         0, 1, 16'h0003, 0, 0, 0, 0, 0, 1, 0};
      vecs[10] = '{0, 0, 0, 0, 0,  1, 0, 0, 0,         0, 1, 16'h0003, 0, 0, 0, 0, 0, 1, 0};
      vecs[11] = '{0, 0, 0, 1, PA, 0, 0, 0, 0,         0, 1, PA,       0, 0, 0, 0, 0, 1, 0};
      vecs[12] = '{0, 0, 0, 1, PA, 1, 0, 0, 0,         0, 1, PA,       1, 0, 0, 0, 0, 1, 0};
      vecs[13] = '{0, 0, 0, 1, PB, 1, 0, 0, 0,         0, 1, PB,       1, 0, 0, 0, 0, 1, 0};
      vecs[14] = '{0, 0, 0, 1, PC, 1, 0, 0, 0,         0, 1, PC,       1, 0, 0, 0, 0, 1, 0};
      vecs[15] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,         1, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 0};
      // T3: X out of range with payload, then Y out of range with len=0
      vecs[16] = '{1, 16'h0400, 2, 0, 0, 1, 0, 0, 0,   1, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 0};
      vecs[17] = '{0, 0, 0, 1, 16'hD001, 1, 0, 0, 0,   0, 0, 16'h0000, 1, 1, 0, 0, 0, 2, 0};
      vecs[18] = '{0, 0, 0, 1, 16'hD002, 1, 0, 0, 0,   0, 0, 16'h0000, 1, 0, 0, 0, 0, 2, 0};
      vecs[19] = '{1, 16'h0004, 0, 0, 0, 1, 0, 0, 0,   1, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 0};
      vecs[20] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,         1, 0, 16'h0000, 0, 1, 0, 0, 0, 2, 0};
      vecs[21] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,         1, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 0};
      // T4: zero-length injection at the in-range corner (3,3)
      vecs[22] = '{1, 16'h0303, 0, 0, 0, 1, 0, 0, 0,   1, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 0};
      vecs[23] = '{0, 0, 0, 0, 0,  1, 0, 0, 0,         0, 1, 16'h0303, 0, 0, 0, 0, 0, 2, 0};
      vecs[24] = '{0, 0, 0, 0, 0,  1, 0, 0, 0,         0, 1, 16'h0000, 0, 0, 0, 0, 0, 2, 0};
      vecs[25] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,         1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 0};
      // T4 eject: zero-length packet
      vecs[26] = '{0, 0, 0, 0, 0,  0, 1, 16'h0303, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 0};
      vecs[27] = '{0, 0, 0, 0, 0,  0, 1, 16'h0000, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 0};
      vecs[28] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,         1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 0};
      vecs[29] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,         1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 1};
      // eject len=2 with junk above LEN_W in size flit, one host stall
      vecs[30] = '{0, 0, 0, 0, 0,  0, 1, 16'h0203, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 1};
      vecs[31] = '{0, 0, 0, 0, 0,  0, 1, 16'h0102, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 1};
      vecs[32] = '{0, 0, 0, 0, 0,  0, 1, 16'h1111, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 1};
      vecs[33] = '{0, 0, 0, 0, 0,  0, 1, 16'h2222, 0,  1, 0, 16'h0000, 0, 0, 1, 16'h1111, 0, 3, 1};
      vecs[34] = '{0, 0, 0, 0, 0,  0, 0, 0, 1,         1, 0, 16'h0000, 0, 0, 1, 16'h1111, 0, 3, 1};
      vecs[35] = '{0, 0, 0, 0, 0,  0, 0, 0, 1,         1, 0, 16'h0000, 0, 0, 1, 16'h2222, 1, 3, 1};
      vecs[36] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,         1, 0, 16'h0000, 0, 0, 0, 0, 0, 3, 2};

      idle_inputs();
      reset = 1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset cmd_ready", cmd_ready, 1);
      chk("reset credit_o", credit_o, 1);
      chk("reset tx", tx, 0);
      chk("reset data_out", data_out, 0);
      chk("reset pl_ready", pl_ready, 0);
      chk("reset rx_valid", rx_valid, 0);
      chk("reset rx_data", rx_data, 0);
      chk("reset rx_last", rx_last, 0);
      chk("reset err_dest", err_dest, 0);
      chk("reset sent_pkts", sent_pkts, 0);
      chk("reset recv_pkts", recv_pkts, 0);
      cyc();
      reset = 0;

      for (int i = 0; i < 37; i++) begin
         cyc();
         cmd_valid = vecs[i].cv;  cmd_dest = vecs[i].dest; cmd_len = vecs[i].len;
         pl_valid  = vecs[i].pv;  pl_data  = vecs[i].pd;   credit_i = vecs[i].cr;
         rx        = vecs[i].rxv; data_in  = vecs[i].din;  rx_ready = vecs[i].rr;
         @(negedge clock);
         chk($sformatf("row%0d cmd_ready", i), cmd_ready, vecs[i].e_cmd_ready);
         chk($sformatf("row%0d tx", i), tx, vecs[i].e_tx);
         chk($sformatf("row%0d data_out", i), data_out, vecs[i].e_dout);
         chk($sformatf("row%0d pl_ready", i), pl_ready, vecs[i].e_pl_ready);
         chk($sformatf("row%0d err_dest", i), err_dest, vecs[i].e_err);
         chk($sformatf("row%0d credit_o", i), credit_o, 1);
         chk($sformatf("row%0d rx_valid", i), rx_valid, vecs[i].e_rx_valid);
         chk($sformatf("row%0d rx_data", i), rx_data, vecs[i].e_rx_data);
         chk($sformatf("row%0d rx_last", i), rx_last, vecs[i].e_rx_last);
         chk($sformatf("row%0d sent_pkts", i), sent_pkts, vecs[i].e_sent);
         chk($sformatf("row%0d recv_pkts", i), recv_pkts, vecs[i].e_recv);
      end

      // T5: 10 flits (hdr, size=8, 8 payload) with host stalled fills the FIFO
      cyc();
      idle_inputs();
      for (int k = 0; k < 10; k++) begin
         cyc();
         rx = 1;
         data_in = (k == 0) ? 16'h0101 : (k == 1) ? 16'h0008 : 16'h5000 + 16'(k - 2);
         @(negedge clock);
         chk($sformatf("t5 push%0d credit_o", k), credit_o, 1);
      end
      cyc();
      rx = 0;
      @(negedge clock);
      chk("t5 full credit_o", credit_o, 0);
      chk("t5 stalled rx_valid", rx_valid, 1);
      for (int k = 0; k < 8; k++) begin
         cyc();
         rx_ready = 1;
         @(negedge clock);
         chk($sformatf("t5 pay%0d rx_valid", k), rx_valid, 1);
         chk($sformatf("t5 pay%0d rx_data", k), rx_data, 16'h5000 + 16'(k));
         chk($sformatf("t5 pay%0d rx_last", k), rx_last, (k == 7) ? 1'b1 : 1'b0);
         if (k == 1) chk("t5 credit_o back", credit_o, 1);
      end
      cyc();
      rx_ready = 0;
      @(negedge clock);
      chk("t5 drained rx_valid", rx_valid, 0);
      chk("t5 recv_pkts", recv_pkts, 3);

      // T6: reset in the middle of a len=5 payload
      cyc();
      cmd_valid = 1; cmd_dest = 16'h0201; cmd_len = 8'd5; credit_i = 1;
      cyc();
      cmd_valid = 0;
      @(negedge clock);
      chk("t6 hdr", data_out, 16'h0201);
      cyc();
      @(negedge clock);
      chk("t6 size", data_out, 16'h0005);
      for (int k = 0; k < 2; k++) begin
         cyc();
         pl_valid = 1; pl_data = 16'h6000 + 16'(k);
         @(negedge clock);
         chk($sformatf("t6 pay%0d", k), data_out, 16'h6000 + 16'(k));
      end
      cyc();
      pl_data = 16'h6002;
      reset = 1;
      @(negedge clock);
      chk("t6 sent before reset", sent_pkts, 3);
      cyc();
      @(negedge clock);
      chk("t6 reset tx", tx, 0);
      chk("t6 reset cmd_ready", cmd_ready, 1);
      chk("t6 reset pl_ready", pl_ready, 0);
      chk("t6 reset sent", sent_pkts, 0);
      chk("t6 reset recv", recv_pkts, 0);
      cyc();
      reset = 0; pl_valid = 0;
      @(negedge clock);
      chk("t6 post-reset tx", tx, 0);
      cyc();
      cmd_valid = 1; cmd_dest = 16'h0302; cmd_len = 8'd1;
      @(negedge clock);
      chk("t6 new cmd_ready", cmd_ready, 1);
      cyc();
      cmd_valid = 0;
      @(negedge clock);
      chk("t6 new hdr", data_out, 16'h0302);
      cyc();
      @(negedge clock);
      chk("t6 new size", data_out, 16'h0001);
      cyc();
      pl_valid = 1; pl_data = 16'hBEEF;
      @(negedge clock);
      chk("t6 new pay tx", tx, 1);
      chk("t6 new pay", data_out, 16'hBEEF);
      cyc();
      pl_valid = 0;
      @(negedge clock);
      chk("t6 new idle tx", tx, 0);
      chk("t6 new sent", sent_pkts, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
